pe_row_cfg_sequencer: RTL and testbench

//  Configuration/run sequencer for one PE row (LSU + PE_D x3 + PE_C). Accepts config

---
 rtl/pe_row_cfg_pkg.sv | 43 ++++
 rtl/run_cycle_counter.sv | 36 +++
 rtl/pe_row_cfg_sequencer.sv | 152 +++++++++++++++
 tb/tb_pe_row_cfg_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_row_cfg_pkg.sv
// Shared definitions for the PE row configuration sequencer.
//   N_TGT        : number of loadable targets in one row (LSU + four PEs)
//   state_t      : sequencer state encoding and its state constants
//   TGT_*        : cfg_tgt codes for each target
//   tgt_onehot() : maps a legal target code to its init_sel bit
//                  (LSU is the MSB, PE3 is the LSB)
package pe_row_cfg_pkg;

  localparam int unsigned N_TGT = 5;

  typedef logic [2:0] state_t;
  localparam state_t StIdle  = 3'd0;
  localparam state_t StLoad  = 3'd1;
  localparam state_t StIssue = 3'd2;
  localparam state_t StRun   = 3'd3;
  localparam state_t StDone  = 3'd4;

  localparam logic [2:0] TGT_LSU = 3'd0;
  localparam logic [2:0] TGT_PE0 = 3'd1;
  localparam logic [2:0] TGT_PE1 = 3'd2;
  localparam logic [2:0] TGT_PE2 = 3'd3;
  localparam logic [2:0] TGT_PE3 = 3'd4;

  localparam logic [N_TGT-1:0] MASK_ALL = '1;

  function automatic logic tgt_legal(input logic [2:0] tgt);
    return tgt <= TGT_PE3;
  endfunction

  function automatic logic [N_TGT-1:0] tgt_onehot(input logic [2:0] tgt);
    logic [N_TGT-1:0] sel;
    case (tgt)
      TGT_LSU: sel = 5'b10000;
      TGT_PE0: sel = 5'b01000;
      TGT_PE1: sel = 5'b00100;
      TGT_PE2: sel = 5'b00010;
      TGT_PE3: sel = 5'b00001;
      default: sel = '0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/run_cycle_counter.sv
// Down-counter holding the remaining run length of a PE row.
//   clk      : clock, rising edge
//   rst      : asynchronous active-low reset
//   load     : load load_val (takes priority over dec)
//   load_val : run length to load
//   dec      : decrement by one; saturates at zero
//   is_zero  : count is zero
//   is_one   : count is one (last run cycle)
module run_cycle_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             is_zero,
  output logic             is_one
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign is_zero = (cnt_q == '0);
  assign is_one  = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/pe_row_cfg_sequencer.sv
// Configuration/run sequencer for one PE row (LSU + PE_D x3 + PE_C).
// Takes config words over a valid/ready stream, loads each into its target with
// PE_config + one-hot init_sel + a one-cycle init_en strobe, and once all five
// targets are loaded runs the row for a programmed number of cycles.
//   clk, rst   : clock (rising edge), asynchronous active-low reset
//   start      : begin a load sequence (IDLE only); latches run_cycles
//   abort      : return to IDLE on the next edge from any state
//   cfg_valid/cfg_ready/cfg_tgt/cfg_data : config word stream
//   PE_config, init_sel, init_en         : load interface to the row
//   run        : row run enable, high for run_cycles cycles
//   busy, done : not idle / one-cycle end-of-run pulse
//   err        : sticky illegal-target flag, cleared by an accepted start
// All outputs are registered; their next values are decoded from state_d.
module pe_row_cfg_sequencer
  import pe_row_cfg_pkg::*;
#(
  parameter int unsigned CFG_W = 64,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] run_cycles,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [2:0]       cfg_tgt,
  input  logic [CFG_W-1:0] cfg_data,
  output logic [CFG_W-1:0] PE_config,
  output logic [N_TGT-1:0] init_sel,
  output logic             init_en,
  output logic             run,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_t           state_q, state_d;
  logic [N_TGT-1:0] mask_q, mask_d, mask_new;
  logic [N_TGT-1:0] sel_q, sel_d;
  logic [CFG_W-1:0] cfg_q, cfg_d;
  logic             err_q, err_d;
  logic             ready_q, en_q, run_q, busy_q, done_q;
  logic             accept, cnt_load, cnt_dec, cnt_zero, cnt_one;

  run_cycle_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .load    (cnt_load),
    .load_val(run_cycles),
    .dec     (cnt_dec),
    .is_zero (cnt_zero),
    .is_one  (cnt_one)
  );

  assign accept   = ready_q & cfg_valid;
  assign mask_new = mask_q | sel_q;

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    sel_d    = sel_q;
    cfg_d    = cfg_q;
    err_d    = err_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    if (abort) begin
      // err survives an abort; a handshake in this cycle is dropped.
      state_d = StIdle;
      mask_d  = '0;
      sel_d   = '0;
      cfg_d   = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            state_d  = StLoad;
            mask_d   = '0;
            err_d    = 1'b0;
            cnt_load = 1'b1;
          end
        end
        StLoad: begin
          if (accept) begin
            if (tgt_legal(cfg_tgt)) begin
              cfg_d   = cfg_data;
              sel_d   = tgt_onehot(cfg_tgt);
              state_d = StIssue;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        StIssue: begin
          // A repeated target leaves the mask unchanged, so it just costs a reload.
          mask_d = mask_new;
          if (mask_new == MASK_ALL) begin
            state_d = cnt_zero ? StDone : StRun;
          end else begin
            state_d = StLoad;
          end
        end
        StRun: begin
          cnt_dec = 1'b1;
          if (cnt_one) begin
            state_d = StDone;
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      mask_q  <= '0;
      sel_q   <= '0;
      cfg_q   <= '0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
      en_q    <= 1'b0;
      run_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      sel_q   <= sel_d;
      cfg_q   <= cfg_d;
      err_q   <= err_d;
      ready_q <= (state_d == StLoad);
      en_q    <= (state_d == StIssue);
      run_q   <= (state_d == StRun);
      busy_q  <= (state_d != StIdle);
      done_q  <= (state_d == StDone);
    end
  end

  assign cfg_ready = ready_q;
  assign init_en   = en_q;
  assign run       = run_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign init_sel  = sel_q;
  assign PE_config = cfg_q;

endmodule

// File: tb/tb_pe_row_cfg_sequencer.sv
// Bench for pe_row_cfg_sequencer: a directed vector table, hand-written corner
// sequences (repeat target, zero run length, abort mid-run, async reset mid-load)
// and a randomized run, all tracked by a transaction-level reference model.
module tb_pe_row_cfg_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start, abort, cfg_valid;
  logic [15:0] run_cycles;
  logic [2:0]  cfg_tgt;
  logic [63:0] cfg_data;
  logic        cfg_ready, init_en, run, busy, done, err;
  logic [63:0] PE_config;
  logic [4:0]  init_sel;

  pe_row_cfg_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .run_cycles(run_cycles),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_tgt   (cfg_tgt),
    .cfg_data  (cfg_data),
    .PE_config (PE_config),
    .init_sel  (init_sel),
    .init_en   (init_en),
    .run       (run),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0, cycle = 0;
  int en_cnt = 0, run_cnt = 0, done_cnt = 0;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Phases of a row job; the model tracks which targets are loaded and how many
  // run cycles remain rather than any hardware encoding.
  typedef enum int {MIdle, MWait, MIssue, MRun, MDone} mphase_t;
  mphase_t     m_phase;
  bit          m_loaded[5];
  int          m_run_left;
  int          m_last_tgt;
  bit          m_err;
  logic [4:0]  m_sel;
  logic [63:0] m_cfg;

  task automatic model_reset();
    m_phase = MIdle;
    foreach (m_loaded[i]) m_loaded[i] = 1'b0;
    m_run_left = 0;
    m_last_tgt = 0;
    m_err = 1'b0;
    m_sel = '0;
    m_cfg = '0;
  endtask

  task automatic model_step(input logic s, input logic a, input logic v, input logic [2:0] t,
                            input logic [63:0] d, input logic [15:0] r);
    if (a) begin
      m_phase = MIdle;
      foreach (m_loaded[i]) m_loaded[i] = 1'b0;
      m_sel = '0;
      m_cfg = '0;
    end else begin
      case (m_phase)
        MIdle: if (s) begin
          m_phase = MWait;
          foreach (m_loaded[i]) m_loaded[i] = 1'b0;
          m_err = 1'b0;
          m_run_left = int'(r);
        end
        MWait: if (v) begin
          if (t < 3'd5) begin
            m_cfg = d;
            m_sel = 5'(5'b10000 >> t);
            m_last_tgt = int'(t);
            m_phase = MIssue;
          end else begin
            m_err = 1'b1;
          end
        end
        MIssue: begin
          m_loaded[m_last_tgt] = 1'b1;
          if (m_loaded[0] && m_loaded[1] && m_loaded[2] && m_loaded[3] && m_loaded[4])
            m_phase = (m_run_left == 0) ? MDone : MRun;
          else
            m_phase = MWait;
        end
        MRun: begin
          if (m_run_left <= 1) m_phase = MDone;
          else m_run_left--;
        end
        default: m_phase = MIdle;
      endcase
    end
  endtask

  task automatic chk_model();
    logic [5:0] fa, fe;
    fa = {cfg_ready, init_en, run, done, busy, err};
    fe = {m_phase == MWait, m_phase == MIssue, m_phase == MRun, m_phase == MDone,
          m_phase != MIdle, m_err};
    n_cmp++;
    if ({fa, init_sel, PE_config} !== {fe, m_sel, m_cfg}) begin
      n_fail++;
      $display("FAIL model cycle %0d: got rdy/en/run/done/busy/err=%b sel=%b cfg=%h expected %b sel=%b cfg=%h",
               cycle, fa, init_sel, PE_config, fe, m_sel, m_cfg);
    end
  endtask

  // One clock: capture inputs seen at the edge, advance the model, check after the edge.
  task automatic tick();
    logic s, a, v;
    logic [2:0] t;
    logic [63:0] d;
    logic [15:0] r;
    s = start; a = abort; v = cfg_valid; t = cfg_tgt; d = cfg_data; r = run_cycles;
    @(posedge clk);
    #1;
    cycle++;
    model_step(s, a, v, t, d, r);
    if (init_en) en_cnt++;
    if (run) run_cnt++;
    if (done) done_cnt++;
    chk_model();
  endtask

  task automatic send_word(input logic [2:0] t, input logic [63:0] d);
    int k = 0;
    while (!cfg_ready && k < 20) begin
      tick();
      k++;
    end
    if (!cfg_ready) chk("wait_cfg_ready", 80'(cfg_ready), 80'(1));
    cfg_valid = 1'b1;
    cfg_tgt = t;
    cfg_data = d;
    tick();
    cfg_valid = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic s, a, v;
    logic [2:0] t;
    logic [63:0] d;
    logic [15:0] r;
    logic rdy, en, rn, dn, bz, er;
    logic [4:0] sel;
    logic [63:0] cfg;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic a, input logic v, input logic [2:0] t,
                              input logic [63:0] d, input logic [15:0] r, input logic rdy,
                              input logic en, input logic rn, input logic dn, input logic bz,
                              input logic er, input logic [4:0] sel, input logic [63:0] cfg);
    vec_t x;
    x.s = s; x.a = a; x.v = v; x.t = t; x.d = d; x.r = r;
    x.rdy = rdy; x.en = en; x.rn = rn; x.dn = dn; x.bz = bz; x.er = er;
    x.sel = sel; x.cfg = cfg;
    return x;
  endfunction

  localparam logic [63:0] D0 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] D1 = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] D2 = 64'h5555_AAAA_0F0F_F0F0;
  localparam logic [63:0] D3 = 64'h8000_0000_0000_0001;
  localparam logic [63:0] D4 = 64'h0000_FFFF_1234_0000;
  localparam logic [63:0] DX = 64'hDEAD_BEEF_DEAD_BEEF;

  vec_t vecs[18];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    start = 0; abort = 0; cfg_valid = 0; cfg_tgt = 0; cfg_data = 0; run_cycles = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_model();
    chk("reset_outputs", {cfg_ready, init_en, run, done, busy, err, init_sel, PE_config}, '0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    //               s a v tgt data rc  | rdy en run dn bz err sel       cfg
    vecs[0]  = mk(1, 0, 0, 0, 0,  3,   1, 0, 0, 0, 1, 0, 5'b00000, 0);
    vecs[1]  = mk(0, 0, 1, 0, D0, 0,   0, 1, 0, 0, 1, 0, 5'b10000, D0);
    vecs[2]  = mk(0, 0, 1, 1, D1, 0,   1, 0, 0, 0, 1, 0, 5'b10000, D0);
    vecs[3]  = mk(0, 0, 1, 1, D1, 0,   0, 1, 0, 0, 1, 0, 5'b01000, D1);
    vecs[4]  = mk(0, 0, 1, 6, DX, 0,   1, 0, 0, 0, 1, 0, 5'b01000, D1);
    vecs[5]  = mk(0, 0, 1, 6, DX, 0,   1, 0, 0, 0, 1, 1, 5'b01000, D1);
    vecs[6]  = mk(0, 0, 1, 2, D2, 0,   0, 1, 0, 0, 1, 1, 5'b00100, D2);
    vecs[7]  = mk(0, 0, 0, 0, 0,  0,   1, 0, 0, 0, 1, 1, 5'b00100, D2);
    vecs[8]  = mk(0, 0, 1, 3, D3, 0,   0, 1, 0, 0, 1, 1, 5'b00010, D3);
    vecs[9]  = mk(0, 0, 0, 0, 0,  0,   1, 0, 0, 0, 1, 1, 5'b00010, D3);
    vecs[10] = mk(0, 0, 1, 4, D4, 0,   0, 1, 0, 0, 1, 1, 5'b00001, D4);
    vecs[11] = mk(0, 0, 0, 0, 0,  0,   0, 0, 1, 0, 1, 1, 5'b00001, D4);
    vecs[12] = mk(1, 0, 0, 0, 0,  7,   0, 0, 1, 0, 1, 1, 5'b00001, D4);
    vecs[13] = mk(0, 0, 0, 0, 0,  0,   0, 0, 1, 0, 1, 1, 5'b00001, D4);
    vecs[14] = mk(0, 0, 0, 0, 0,  0,   0, 0, 0, 1, 1, 1, 5'b00001, D4);
    vecs[15] = mk(0, 0, 0, 0, 0,  0,   0, 0, 0, 0, 0, 1, 5'b00001, D4);
    vecs[16] = mk(1, 1, 0, 0, 0,  5,   0, 0, 0, 0, 0, 1, 5'b00000, 0);
    vecs[17] = mk(1, 0, 0, 0, 0,  0,   1, 0, 0, 0, 1, 0, 5'b00000, 0);

    for (int i = 0; i < 18; i++) begin
      start = vecs[i].s; abort = vecs[i].a; cfg_valid = vecs[i].v;
      cfg_tgt = vecs[i].t; cfg_data = vecs[i].d; run_cycles = vecs[i].r;
      tick();
      chk($sformatf("vec%0d", i),
          {cfg_ready, init_en, run, done, busy, err, init_sel, PE_config},
          {vecs[i].rdy, vecs[i].en, vecs[i].rn, vecs[i].dn, vecs[i].bz, vecs[i].er,
           vecs[i].sel, vecs[i].cfg});
    end
    start = 0; abort = 0; cfg_valid = 0;

    // Repeat target 2 with run_cycles=0: six loads, no RUN, straight to DONE.
    en_cnt = 0; run_cnt = 0; done_cnt = 0;
    send_word(3'd2, D2);
    send_word(3'd2, D3);
    send_word(3'd0, D0);
    send_word(3'd1, D1);
    send_word(3'd3, D3);
    tick();
    chk("repeat_still_loading", {cfg_ready, busy, run}, 80'b110);
    send_word(3'd4, D4);
    tick();
    chk("zero_run_done", {done, run}, 80'b10);
    tick();
    chk("zero_run_idle", busy, 0);
    chk("repeat_en_pulses", 80'(en_cnt), 80'(6));
    chk("zero_run_no_run", 80'(run_cnt), 80'(0));
    chk("zero_run_done_pulses", 80'(done_cnt), 80'(1));

    // Abort mid-RUN with a long run length, then restart and run to completion.
    start = 1; run_cycles = 10;
    tick();
    start = 0;
    for (int t = 0; t < 5; t++) send_word(3'(t), 64'(t + 100));
    repeat (4) tick();
    chk("abort_pre_run", run, 1);
    abort = 1;
    tick();
    abort = 0;
    chk("abort_cleared", {run, busy, init_en, init_sel, PE_config}, '0);
    start = 1; run_cycles = 2;
    tick();
    start = 0;
    chk("restart_ready", {cfg_ready, busy}, 80'b11);
    run_cnt = 0;
    for (int t = 4; t >= 0; t--) send_word(3'(t), 64'(t + 200));
    for (int k = 0; k < 20 && !done; k++) tick();
    chk("restart_done", done, 1);
    chk("restart_run_len", 80'(run_cnt), 80'(2));
    tick();

    // Asynchronous reset while in ISSUE: outputs drop immediately.
    start = 1; run_cycles = 1;
    tick();
    start = 0;
    send_word(3'd1, D1);
    chk("issue_before_rst", init_en, 1);
    #3 rst = 1'b0;
    #1;
    model_reset();
    chk("async_rst_outputs", {cfg_ready, init_en, run, done, busy, err, init_sel, PE_config}, '0);
    #2 rst = 1'b1;
    tick();
    tick();

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      start = ($urandom_range(0, 9) == 0);
      abort = ($urandom_range(0, 59) == 0);
      cfg_valid = 1'($urandom_range(0, 1));
      cfg_tgt = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      cfg_data = {$urandom(), $urandom()};
      run_cycles = 16'($urandom_range(0, 6));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
